bcd_addsub_seq: RTL and testbench

- Digit-serial BCD adder/subtractor for the calculator datapath. It generalises the fixed 2-digit subtractor to DIGITS decimal digits, adds an add/sub mode, and adds a start/busy/done handshake.
- Works natively in BCD using ten's complement; no binary conversion stage.
- Subtraction returns a magnitude plus a sign flag.
- Sits between the keypad operand registers and the display driver.

---
 rtl/bcd_addsub_seq.sv | 110 +++++++++++
 tb/tb_bcd_addsub_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_addsub_seq.sv
// bcd_addsub_seq: digit-serial BCD add/sub with ten's-complement sign fix; optional operand check via BCD_VALIDATE_EN
module bcd_addsub_seq #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op,
  input  logic [4*DIGITS-1:0] a_bcd,
  input  logic [4*DIGITS-1:0] b_bcd,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                neg,
  output logic                carry_out,
  output logic                invalid
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0]  a_r, b_r;
  logic          op_r, carry, cy, last, bad;
  logic [IW-1:0] idx;
  logic [3:0]    da, db, digit;
  logic [4:0]    s;

  function automatic logic [W-1:0] nines(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'd9 - v[4*i +: 4];
    return r;
  endfunction

`ifdef BCD_VALIDATE_EN
  // flag any operand digit above 9 on the inputs being accepted
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad = bad | (a_bcd[4*i +: 4] > 4'd9) | (b_bcd[4*i +: 4] > 4'd9);
  end
`else
  assign bad = 1'b0;
`endif

  // one BCD digit step; FIX reuses it as 9's complement of result plus running carry
  always_comb begin
    da    = state == FIX ? 4'd9 - result[{idx, 2'b00} +: 4] : a_r[{idx, 2'b00} +: 4];
    db    = state == FIX ? 4'd0 : b_r[{idx, 2'b00} +: 4];
    s     = {1'b0, da} + {1'b0, db} + {4'b0, carry};
    cy    = s > 5'd9;
    digit = cy ? s[3:0] + 4'd6 : s[3:0];
    last  = idx == IW'(DIGITS - 1);
  end

  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;

  // next-state and handshake outputs
  always_comb begin
    state_n = state;
    busy    = state == CALC || state == FIX;
    done    = state == DONE;
    case (state)
      IDLE:    state_n = start ? (bad ? DONE : CALC) : IDLE;
      CALC:    state_n = !last ? CALC : (op_r && !cy) ? FIX : DONE;
      FIX:     state_n = last ? DONE : FIX;
      default: state_n = IDLE;
    endcase
  end

  // operand capture, digit-serial result build and flag updates
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      result    <= '0;
      neg       <= 1'b0;
      carry_out <= 1'b0;
      invalid   <= 1'b0;
    end else if (state == IDLE && start) begin
      op_r    <= op;
      a_r     <= a_bcd;
      b_r     <= op ? nines(b_bcd) : b_bcd;
      carry   <= op;
      idx     <= '0;
      invalid <= bad;
      if (bad) begin
        result    <= '0;
        neg       <= 1'b0;
        carry_out <= 1'b0;
      end
    end else if (state == CALC || state == FIX) begin
      result[{idx, 2'b00} +: 4] <= digit;
      carry                     <= cy;
      idx                       <= idx + 1'b1;
      if (state == CALC && last) begin
        carry_out <= !op_r && cy;
        neg       <= op_r && !cy;
        if (op_r && !cy) begin
          idx   <= '0;
          carry <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_addsub_seq.sv
// tb_bcd_addsub_seq: random and directed checks of bcd_addsub_seq against a decimal-arithmetic model
module tb_bcd_addsub_seq;
  localparam int D = 4;
  logic clk = 0, rst = 1, start = 0, op = 0;
  logic [4*D-1:0] a_bcd = '0, b_bcd = '0, result;
  logic busy, done, neg, carry_out, invalid;
  int tests = 0, fails = 0;

  bcd_addsub_seq #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a_bcd(a_bcd), .b_bcd(b_bcd),
    .busy(busy), .done(done), .result(result), .neg(neg), .carry_out(carry_out), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int dec(input logic [4*D-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [4*D-1:0] tobcd(input int x);
    logic [4*D-1:0] r;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4*D-1:0] rnd_bcd();
    logic [4*D-1:0] r;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(9));
    return r;
  endfunction

  // model: cyc counts cycles since accept (0 = idle), lat = cycle holding done
  int cyc = 0, lat = 0, lim = 1;
  bit live = 0;
  logic [4*D-1:0] pres, ores;
  logic pneg, pco, pinv, oneg, oco, oinv;

  always @(posedge clk) begin
    if (rst) begin
      live = 1;
      cyc  = 0;
      ores = '0; oneg = 0; oco = 0; oinv = 0;
    end else if (cyc == 0) begin
      if (start) begin
        int av, bv;
        av = dec(a_bcd); bv = dec(b_bcd);
        pinv = 0; pco = 0; pneg = 0;
        lim = 1;
        for (int i = 0; i < D; i++) lim = lim * 10;
        if (!op) begin
          pres = tobcd((av + bv) % lim);
          pco  = (av + bv) >= lim;
          lat  = D + 1;
        end else if (av >= bv) begin
          pres = tobcd(av - bv);
          lat  = D + 1;
        end else begin
          pres = tobcd(bv - av);
          pneg = 1;
          lat  = 2 * D + 1;
        end
`ifdef BCD_VALIDATE_EN
        for (int i = 0; i < D; i++)
          if (a_bcd[4*i +: 4] > 4'd9 || b_bcd[4*i +: 4] > 4'd9) pinv = 1;
        if (pinv) begin
          pres = '0; pco = 0; pneg = 0; lat = 1;
        end
`endif
        cyc = 1;
        if (cyc == lat) begin
          ores = pres; oneg = pneg; oco = pco; oinv = pinv;
        end
      end
    end else if (cyc == lat) begin
      cyc = 0;
    end else begin
      cyc++;
      if (cyc == lat) begin
        ores = pres; oneg = pneg; oco = pco; oinv = pinv;
      end
    end
  end

  // compare every cycle; result flags only where they must be stable
  always @(negedge clk) begin
    if (live) begin
      chk("busy", busy, cyc != 0 && cyc < lat);
      chk("done", done, cyc != 0 && cyc == lat);
      if (cyc == 0 || cyc == lat) begin
        chk("result", result, ores);
        chk("neg", neg, oneg);
        chk("carry_out", carry_out, oco);
        chk("invalid", invalid, oinv);
      end
    end
  end

  task automatic run_op(input logic o, input logic [4*D-1:0] a, input logic [4*D-1:0] b,
                        input logic [4*D-1:0] er, input logic en, input logic eco,
                        input logic einv, input int el);
    int n;
    @(negedge clk);
    start = 1; op = o; a_bcd = a; b_bcd = b;
    @(negedge clk);
    start = 0;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("lit_latency", n, el);
    chk("lit_result", result, er);
    chk("lit_neg", neg, en);
    chk("lit_carry_out", carry_out, eco);
    chk("lit_invalid", invalid, einv);
  endtask

  initial begin
    int dones;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("lit_reset_busy", busy, 0);
    chk("lit_reset_result", result, 0);
    run_op(0, 16'h1234, 16'h4321, 16'h5555, 0, 0, 0, 5);
    run_op(0, 16'h9999, 16'h0001, 16'h0000, 0, 1, 0, 5);
    run_op(0, 16'h0999, 16'h0001, 16'h1000, 0, 0, 0, 5);
    run_op(1, 16'h0025, 16'h0150, 16'h0125, 1, 0, 0, 9);
    run_op(1, 16'h0150, 16'h0025, 16'h0125, 0, 0, 0, 5);
    run_op(1, 16'h0150, 16'h0150, 16'h0000, 0, 0, 0, 5);
    run_op(1, 16'h0000, 16'h9999, 16'h9999, 1, 0, 0, 9);
`ifdef BCD_VALIDATE_EN
    run_op(0, 16'h00A1, 16'h0001, 16'h0000, 0, 0, 1, 1);
    run_op(0, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0, 5);
`endif
    // start pulses in cycles 2 and 5 of an add are ignored
    @(negedge clk);
    start = 1; op = 0; a_bcd = 16'h1234; b_bcd = 16'h4321;
    dones = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      dones += int'(done);
      start = (k == 2 || k == 5);
      if (k == 2) begin a_bcd = 16'h9999; b_bcd = 16'h9999; end
    end
    chk("lit_ignored_dones", dones, 1);
    chk("lit_ignored_result", result, 16'h5555);
    // start held high: accepts only from IDLE, every D+2 cycles
    start = 1; op = 1; a_bcd = 16'h0150; b_bcd = 16'h0025;
    dones = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      dones += int'(done);
      if (k == 30) start = 0;
    end
    chk("lit_held_dones", dones, 5);
    @(negedge clk);
    // reset in cycle 3 of a subtraction aborts it
    start = 1; op = 1; a_bcd = 16'h0025; b_bcd = 16'h0150;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("lit_abort_busy", busy, 0);
    chk("lit_abort_done", done, 0);
    chk("lit_abort_result", result, 0);
    chk("lit_abort_neg", neg, 0);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      dones += int'(done);
    end
    chk("lit_abort_no_done", dones, 0);
    run_op(1, 16'h0025, 16'h0150, 16'h0125, 1, 0, 0, 9);
    // random operations with random idle gaps and occasional stray start pulses
    for (int t = 0; t < 300; t++) begin
      int g;
      @(negedge clk);
      start = 1; op = 1'($urandom_range(1));
      a_bcd = rnd_bcd(); b_bcd = rnd_bcd();
      if (t % 7 == 0) a_bcd = b_bcd;
      @(negedge clk);
      start = 0;
      g = 0;
      while (!done && g < 40) begin
        @(negedge clk);
        start = ($urandom_range(9) == 0);
        g++;
      end
      start = 0;
      if (g >= 40) chk("random_timeout", g, 0);
      repeat ($urandom_range(2)) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
